// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator in the pixel clock domain.
// The horizontal and vertical phase machines drive registered sync, data-enable, coordinate and start-pulse outputs.
module dvi_timing_gen #(
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int H_ACTIVE      = 640,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int V_ACTIVE      = 480,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int W             = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         hsync,
    output logic         vsync,
    output logic         den,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         frame_start,
    output logic         line_start
);

    typedef enum logic [1:0] {
        ST_FRONT  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_BACK   = 2'd2,
        ST_ACTIVE = 2'd3
    } phase_e;

    localparam logic [W-1:0] ZERO     = {W{1'b0}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] H_FP_END = W'(H_FRONT_PORCH - 1);
    localparam logic [W-1:0] H_SY_END = W'(H_SYNC_WIDTH - 1);
    localparam logic [W-1:0] H_BP_END = W'(H_BACK_PORCH - 1);
    localparam logic [W-1:0] H_AC_END = W'(H_ACTIVE - 1);
    localparam logic [W-1:0] V_FP_END = W'(V_FRONT_PORCH - 1);
    localparam logic [W-1:0] V_SY_END = W'(V_SYNC_WIDTH - 1);
    localparam logic [W-1:0] V_BP_END = W'(V_BACK_PORCH - 1);
    localparam logic [W-1:0] V_AC_END = W'(V_ACTIVE - 1);

    function automatic phase_e next_phase(input phase_e s);
        case (s)
            ST_FRONT:  next_phase = ST_SYNC;
            ST_SYNC:   next_phase = ST_BACK;
            ST_BACK:   next_phase = ST_ACTIVE;
            ST_ACTIVE: next_phase = ST_FRONT;
            default:   next_phase = ST_FRONT;
        endcase
    endfunction

    function automatic logic [W-1:0] h_last(input phase_e s);
        case (s)
            ST_FRONT:  h_last = H_FP_END;
            ST_SYNC:   h_last = H_SY_END;
            ST_BACK:   h_last = H_BP_END;
            ST_ACTIVE: h_last = H_AC_END;
            default:   h_last = H_FP_END;
        endcase
    endfunction

    function automatic logic [W-1:0] v_last(input phase_e s);
        case (s)
            ST_FRONT:  v_last = V_FP_END;
            ST_SYNC:   v_last = V_SY_END;
            ST_BACK:   v_last = V_BP_END;
            ST_ACTIVE: v_last = V_AC_END;
            default:   v_last = V_FP_END;
        endcase
    endfunction

    phase_e         h_state_q, h_state_d;
    phase_e         v_state_q, v_state_d;
    logic [W-1:0]   hcount_q, hcount_d;
    logic [W-1:0]   vcount_q, vcount_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           den_q, den_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic           frame_start_q, frame_start_d;
    logic           line_start_q, line_start_d;
    logic           eol_s;

    // Next state of both phase machines; outputs decode from that next state so they track the state with no lag.
    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        eol_s     = 1'b0;
        if (en) begin
            if (hcount_q == h_last(h_state_q)) begin
                hcount_d  = ZERO;
                h_state_d = next_phase(h_state_q);
                eol_s     = (h_state_q == ST_ACTIVE);
            end else begin
                hcount_d  = hcount_q + ONE;
            end
            // The vertical machine steps once per line, on the last visible pixel.
            if (eol_s) begin
                if (vcount_q == v_last(v_state_q)) begin
                    vcount_d  = ZERO;
                    v_state_d = next_phase(v_state_q);
                end else begin
                    vcount_d  = vcount_q + ONE;
                end
            end else begin
                vcount_d = vcount_q;
            end
        end else begin
            eol_s = 1'b0;
        end

        hsync_d       = (h_state_d == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = (v_state_d == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
        den_d         = (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
        x_d           = den_d ? hcount_d : ZERO;
        y_d           = (v_state_d == ST_ACTIVE) ? vcount_d : ZERO;
        line_start_d  = den_d && (x_d == ZERO);
        frame_start_d = line_start_d && (y_d == ZERO);
    end

    // State and output registers with synchronous reset taking priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_state_q     <= ST_FRONT;
            v_state_q     <= ST_FRONT;
            hcount_q      <= ZERO;
            vcount_q      <= ZERO;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            den_q         <= 1'b0;
            x_q           <= ZERO;
            y_q           <= ZERO;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            den_q         <= den_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign den         = den_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen: default, inverted-polarity and tiny-parameter instances run in lockstep.
module tb_dvi_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    logic        a_hs, a_vs, a_den, a_fs, a_ls;
    logic [11:0] a_x, a_y;
    logic        p_hs, p_vs, p_den, p_fs, p_ls;
    logic [11:0] p_x, p_y;
    logic        s_hs, s_vs, s_den, s_fs, s_ls;
    logic [11:0] s_x, s_y;

    dvi_timing_gen dut_a (
        .clk(clk), .rst(rst), .en(en), .hsync(a_hs), .vsync(a_vs), .den(a_den),
        .x(a_x), .y(a_y), .frame_start(a_fs), .line_start(a_ls)
    );

    dvi_timing_gen #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dut_p (
        .clk(clk), .rst(rst), .en(en), .hsync(p_hs), .vsync(p_vs), .den(p_den),
        .x(p_x), .y(p_y), .frame_start(p_fs), .line_start(p_ls)
    );

    dvi_timing_gen #(
        .H_FRONT_PORCH(1), .H_SYNC_WIDTH(1), .H_BACK_PORCH(1), .H_ACTIVE(4),
        .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1), .V_ACTIVE(2)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .hsync(s_hs), .vsync(s_vs), .den(s_den),
        .x(s_x), .y(s_y), .frame_start(s_fs), .line_start(s_ls)
    );

    logic [28:0] obs_a, obs_p, obs_s;
    assign obs_a = {a_hs, a_vs, a_den, a_fs, a_ls, a_x, a_y};
    assign obs_p = {p_hs, p_vs, p_den, p_fs, p_ls, p_x, p_y};
    assign obs_s = {s_hs, s_vs, s_den, s_fs, s_ls, s_x, s_y};

    localparam logic [28:0] SYNC_FLIP = {2'b11, 27'd0};

    function automatic logic [28:0] e(input logic hs, input logic vs, input logic de,
                                      input logic fs, input logic ls, input int xx, input int yy);
        return {hs, vs, de, fs, ls, 12'(xx), 12'(yy)};
    endfunction

    task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: got hs=%b vs=%b den=%b fs=%b ls=%b x=%0d y=%0d, expected hs=%b vs=%b den=%b fs=%b ls=%b x=%0d y=%0d",
                   tag, cyc, obs[28], obs[27], obs[26], obs[25], obs[24], obs[23:12], obs[11:0],
                   exp[28], exp[27], exp[26], exp[25], exp[24], exp[23:12], exp[11:0]);
        end
    endtask

    // Default instance and its inverted-polarity twin share one expectation.
    task automatic chk_ap(input string tag, input logic [28:0] exp);
        chk({tag, "_def"}, obs_a, exp);
        chk({tag, "_pol"}, obs_p, exp ^ SYNC_FLIP);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic run_tog(input int target);
        while (cyc < target) begin
            en = ((cyc % 3) == 2);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    logic [28:0] idle_v;

    initial begin
        idle_v = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Free run from reset with en held high.
        do_reset();
        chk_ap("rst_state", idle_v);
        chk("s_rst_state", obs_s, idle_v);
        run_to(7);     chk("s_vsync_on",  obs_s, e(1, 0, 0, 0, 0, 0, 0));
        run_to(14);    chk("s_vsync_off", obs_s, idle_v);
        run_to(15);    chk_ap("hfp_last", idle_v);
        run_to(16);    chk_ap("hsync_on", e(0, 1, 0, 0, 0, 0, 0));
        run_to(23);    chk("s_pre_den",   obs_s, idle_v);
        run_to(24);    chk("s_first_den", obs_s, e(1, 1, 1, 1, 1, 0, 0));
        run_to(27);    chk("s_line0_end", obs_s, e(1, 1, 1, 0, 0, 3, 0));
        run_to(28);    chk("s_line1_fp",  obs_s, e(1, 1, 0, 0, 0, 0, 1));
        run_to(31);    chk("s_line1_den", obs_s, e(1, 1, 1, 0, 1, 0, 1));
        run_to(34);    chk("s_last_px",   obs_s, e(1, 1, 1, 0, 0, 3, 1));
        run_to(35);    chk("s_wrap",      obs_s, idle_v);
        run_to(36);    chk("s_wrap_sync", obs_s, e(0, 1, 0, 0, 0, 0, 0));
        run_to(59);    chk("s_frame2",    obs_s, e(1, 1, 1, 1, 1, 0, 0));
        run_to(111);   chk_ap("hsync_last", e(0, 1, 0, 0, 0, 0, 0));
        run_to(112);   chk_ap("hsync_off", idle_v);
        run_to(7999);  chk_ap("pre_vsync", idle_v);
        run_to(8000);  chk_ap("vsync_on", e(1, 0, 0, 0, 0, 0, 0));
        run_to(9599);  chk_ap("vsync_last", e(1, 0, 0, 0, 0, 0, 0));
        run_to(9600);  chk_ap("vsync_off", idle_v);
        run_to(36159); chk_ap("pre_den", idle_v);
        run_to(36160); chk_ap("first_den", e(1, 1, 1, 1, 1, 0, 0));
        run_to(36161); chk_ap("second_px", e(1, 1, 1, 0, 0, 1, 0));
        run_to(36799); chk_ap("line_end", e(1, 1, 1, 0, 0, 639, 0));
        run_to(36800); chk_ap("y_step", e(1, 1, 0, 0, 0, 0, 1));
        run_to(36960); chk_ap("line1_start", e(1, 1, 1, 0, 1, 0, 1));
        run_to(37260); chk_ap("mid_line", e(1, 1, 1, 0, 0, 300, 1));

        // One-cycle reset in the middle of a visible line, with en still high.
        rst = 1'b1;
        tick();
        chk_ap("midrst_state", idle_v);
        chk("s_midrst_state", obs_s, idle_v);
        rst = 1'b0;
        cyc = 0;
        run_to(15);  chk_ap("re_hfp_last", idle_v);
        run_to(16);  chk_ap("re_hsync_on", e(0, 1, 0, 0, 0, 0, 0));
        run_to(24);  chk("s_re_first_den", obs_s, e(1, 1, 1, 1, 1, 0, 0));
        run_to(112); chk_ap("re_hsync_off", idle_v);

        // en high one cycle in three: every value is held for three cycles.
        do_reset();
        chk_ap("tog_rst", idle_v);
        run_tog(47);  chk_ap("tog_pre_hsync", idle_v);
        run_tog(48);  chk_ap("tog_hsync_on", e(0, 1, 0, 0, 0, 0, 0));
        run_tog(71);  chk("s_tog_pre_den", obs_s, idle_v);
        run_tog(72);  chk("s_tog_den0", obs_s, e(1, 1, 1, 1, 1, 0, 0));
        run_tog(73);  chk("s_tog_den1", obs_s, e(1, 1, 1, 1, 1, 0, 0));
        run_tog(74);  chk("s_tog_den2", obs_s, e(1, 1, 1, 1, 1, 0, 0));
        run_tog(75);  chk("s_tog_x1", obs_s, e(1, 1, 1, 0, 0, 1, 0));
        run_tog(335); chk_ap("tog_hsync_last", e(0, 1, 0, 0, 0, 0, 0));
        run_tog(336); chk_ap("tog_hsync_off", idle_v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
